// File: rtl/rf_writeback_queue.sv
// In-order write-back FIFO feeding the two register-file write ports.
// Optional forwarding lookup is enabled with `define RFWB_FWD_EN.
module rf_writeback_queue #(
  parameter int word_width = 32,
  parameter int addr_size  = 5,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in0_valid,
  input  logic [addr_size-1:0]         in0_addr,
  input  logic [word_width-1:0]        in0_data,
  input  logic                         in1_valid,
  input  logic [addr_size-1:0]         in1_addr,
  input  logic [word_width-1:0]        in1_data,
  output logic                         in_ready,
  input  logic                         hold,
  output logic                         we1,
  output logic [addr_size-1:0]         wa1,
  output logic [word_width-1:0]        wd1,
  output logic                         we2,
  output logic [addr_size-1:0]         wa2,
  output logic [word_width-1:0]        wd2,
`ifdef RFWB_FWD_EN
  input  logic [addr_size-1:0]         fra1,
  input  logic [addr_size-1:0]         fra2,
  input  logic [addr_size-1:0]         fra3,
  output logic                         fhit1,
  output logic                         fhit2,
  output logic                         fhit3,
  output logic [word_width-1:0]        fdata1,
  output logic [word_width-1:0]        fdata2,
  output logic [word_width-1:0]        fdata3,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] RDY_THR = CW'(DEPTH - 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [addr_size-1:0] ADDR_ZERO = {addr_size{1'b0}};

  logic [addr_size-1:0]  mem_addr_q [DEPTH];
  logic [addr_size-1:0]  mem_addr_d [DEPTH];
  logic [word_width-1:0] mem_data_q [DEPTH];
  logic [word_width-1:0] mem_data_d [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_nxt1_s, wr_slot1_s;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d, full_q, full_d, empty_q, empty_d;

  logic                  we1_q, we1_d, we2_q, we2_d;
  logic [addr_size-1:0]  wa1_q, wa1_d, wa2_q, wa2_d;
  logic [word_width-1:0] wd1_q, wd1_d, wd2_q, wd2_d;

  logic       lane0_ok_s, lane1_ok_s, pop0_s, pop1_s;
  logic [1:0] enq_n_s, pop_n_s;

  // Enqueue qualification, pop decision and occupancy update
  always_comb begin
    lane0_ok_s    = in_ready_q && in0_valid && (in0_addr != ADDR_ZERO);
    lane1_ok_s    = in_ready_q && in1_valid && (in1_addr != ADDR_ZERO);
    rd_ptr_nxt1_s = rd_ptr_q + PW'(1'b1);
    wr_slot1_s    = lane0_ok_s ? (wr_ptr_q + PW'(1'b1)) : wr_ptr_q;
    pop0_s        = !hold && (count_q != {CW{1'b0}});
    // A same-address second entry waits a cycle so the two ports never collide
    pop1_s        = pop0_s && (count_q >= CW'(2'd2)) &&
                    (mem_addr_q[rd_ptr_nxt1_s] != mem_addr_q[rd_ptr_q]);
    enq_n_s       = {1'b0, lane0_ok_s} + {1'b0, lane1_ok_s};
    pop_n_s       = {1'b0, pop0_s} + {1'b0, pop1_s};
    wr_ptr_d      = wr_ptr_q + PW'(enq_n_s);
    rd_ptr_d      = rd_ptr_q + PW'(pop_n_s);
    count_d       = count_q + CW'(enq_n_s) - CW'(pop_n_s);
    in_ready_d    = (count_d <= RDY_THR);
    full_d        = (count_d == CNT_MAX);
    empty_d       = (count_d == {CW{1'b0}});
  end

  // Storage writes: lane 0 takes the next slot, lane 1 the one after it
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (lane0_ok_s && (wr_ptr_q == PW'(i))) begin
        mem_addr_d[i] = in0_addr;
        mem_data_d[i] = in0_data;
      end else if (lane1_ok_s && (wr_slot1_s == PW'(i))) begin
        mem_addr_d[i] = in1_addr;
        mem_data_d[i] = in1_data;
      end else begin
        mem_addr_d[i] = mem_addr_q[i];
        mem_data_d[i] = mem_data_q[i];
      end
    end
  end

  // Write-port drive: address/data hold when the port does not fire
  always_comb begin
    we1_d = pop0_s;
    we2_d = pop1_s;
    wa1_d = pop0_s ? mem_addr_q[rd_ptr_q]      : wa1_q;
    wd1_d = pop0_s ? mem_data_q[rd_ptr_q]      : wd1_q;
    wa2_d = pop1_s ? mem_addr_q[rd_ptr_nxt1_s] : wa2_q;
    wd2_d = pop1_s ? mem_data_q[rd_ptr_nxt1_s] : wd2_q;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      in_ready_q <= 1'b1;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      we1_q      <= 1'b0;
      we2_q      <= 1'b0;
      wa1_q      <= {addr_size{1'b0}};
      wa2_q      <= {addr_size{1'b0}};
      wd1_q      <= {word_width{1'b0}};
      wd2_q      <= {word_width{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= {addr_size{1'b0}};
        mem_data_q[i] <= {word_width{1'b0}};
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      we1_q      <= we1_d;
      we2_q      <= we2_d;
      wa1_q      <= wa1_d;
      wa2_q      <= wa2_d;
      wd1_q      <= wd1_d;
      wd2_q      <= wd2_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= mem_addr_d[i];
        mem_data_q[i] <= mem_data_d[i];
      end
    end
  end

  assign in_ready = in_ready_q;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign we1      = we1_q;
  assign we2      = we2_q;
  assign wa1      = wa1_q;
  assign wa2      = wa2_q;
  assign wd1      = wd1_q;
  assign wd2      = wd2_q;

`ifdef RFWB_FWD_EN
  logic [addr_size-1:0] fra_s [3];
  assign fra_s[0] = fra1;
  assign fra_s[1] = fra2;
  assign fra_s[2] = fra3;

  for (genvar g = 0; g < 3; g++) begin : g_fwd
    logic                  hit_s;
    logic [word_width-1:0] data_s;
    logic [PW-1:0]         idx_s;
    logic                  m_s;

    // Scan oldest to youngest (port 1, port 2, queue head..tail); last match wins
    always_comb begin
      idx_s  = rd_ptr_q;
      m_s    = we1_q && (wa1_q == fra_s[g]);
      hit_s  = m_s;
      data_s = m_s ? wd1_q : {word_width{1'b0}};
      m_s    = we2_q && (wa2_q == fra_s[g]);
      hit_s  = hit_s | m_s;
      data_s = m_s ? wd2_q : data_s;
      for (int i = 0; i < DEPTH; i++) begin
        idx_s  = rd_ptr_q + PW'(i);
        m_s    = (CW'(i) < count_q) && (mem_addr_q[idx_s] == fra_s[g]);
        hit_s  = hit_s | m_s;
        data_s = m_s ? mem_data_q[idx_s] : data_s;
      end
      hit_s = hit_s && (fra_s[g] != ADDR_ZERO);
    end
  end

  assign fhit1  = g_fwd[0].hit_s;
  assign fhit2  = g_fwd[1].hit_s;
  assign fhit3  = g_fwd[2].hit_s;
  assign fdata1 = g_fwd[0].data_s;
  assign fdata2 = g_fwd[1].data_s;
  assign fdata3 = g_fwd[2].data_s;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Scoreboard bench: stimulus pushes expected register-file writes, a negedge
// monitor pops and compares every we1/we2 write in order.
module tb_rf_writeback_queue;
  localparam int WW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 8;
  localparam int CW = 4;

  logic          clk, rst, hold;
  logic          in0_valid, in1_valid;
  logic [AW-1:0] in0_addr, in1_addr;
  logic [WW-1:0] in0_data, in1_data;
  logic          in_ready, we1, we2, full, empty;
  logic [AW-1:0] wa1, wa2;
  logic [WW-1:0] wd1, wd2;
  logic [CW-1:0] count;

  rf_writeback_queue #(.word_width(WW), .addr_size(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_addr(in0_addr), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_addr(in1_addr), .in1_data(in1_data),
    .in_ready(in_ready), .hold(hold),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .we2(we2), .wa2(wa2), .wd2(wd2),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [WW-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_write(input string port, input logic [AW-1:0] a, input logic [WW-1:0] d);
    wr_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected: got addr %0d data 0x%0h expected no write", port, a, d);
    end else begin
      e = sb.pop_front();
      if (a !== e.a || d !== e.d) begin
        n_fail++;
        $display("FAIL %s_write: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                 port, a, d, e.a, e.d);
      end
    end
  endtask

  // Monitor: port 1 carries the older entry, so it is popped first
  always @(negedge clk) begin
    if (mon_en) begin
      if (we1 === 1'b1) mon_write("port1", wa1, wd1);
      if (we2 === 1'b1) mon_write("port2", wa2, wd2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lanes(input logic v0, input logic [AW-1:0] a0, input logic [WW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [WW-1:0] d1);
    in0_valid = v0; in0_addr = a0; in0_data = d0;
    in1_valid = v1; in1_addr = a1; in1_data = d1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [WW-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    rst = 1'b1;
    hold = 1'b0;
    lanes(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    chk("rst_we1", {31'b0, we1}, 32'd0);
    chk("rst_we2", {31'b0, we2}, 32'd0);
    chk("rst_wa1", {27'b0, wa1}, 32'd0);
    chk("rst_wd2", wd2, 32'd0);
    chk("rst_count", {28'b0, count}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Two distinct addresses drain together
    lanes(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    push(5'd3, 32'h11);
    push(5'd7, 32'h22);
    tick();
    chk("t1_count_after_enq", {28'b0, count}, 32'd2);
    lanes(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("t1_we1", {31'b0, we1}, 32'd1);
    chk("t1_wa1", {27'b0, wa1}, 32'd3);
    chk("t1_we2", {31'b0, we2}, 32'd1);
    chk("t1_wd2", wd2, 32'h22);
    chk("t1_count", {28'b0, count}, 32'd0);
    tick();

    // Same address: serialised over two edges
    lanes(1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 32'hB);
    push(5'd5, 32'hA);
    push(5'd5, 32'hB);
    tick();
    lanes(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("t2_first_wd1", wd1, 32'hA);
    chk("t2_first_we2", {31'b0, we2}, 32'd0);
    chk("t2_first_count", {28'b0, count}, 32'd1);
    tick();
    chk("t2_second_we1", {31'b0, we1}, 32'd1);
    chk("t2_second_wd1", wd1, 32'hB);
    chk("t2_second_we2", {31'b0, we2}, 32'd0);
    tick();

    // Address-0 filter
    lanes(1'b1, 5'd0, 32'hFF, 1'b1, 5'd9, 32'h1);
    push(5'd9, 32'h1);
    tick();
    chk("t3_count", {28'b0, count}, 32'd1);
    lanes(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("t3_wa1", {27'b0, wa1}, 32'd9);
    chk("t3_we2", {31'b0, we2}, 32'd0);
    chk("t3_count_after", {28'b0, count}, 32'd0);
    tick();

    // Fill under hold: in_ready stays 1 up to count 6, so four pairs fit
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lanes(1'b1, 5'(2*k+1), 32'h100 + 32'(2*k+1), 1'b1, 5'(2*k+2), 32'h100 + 32'(2*k+2));
      push(5'(2*k+1), 32'h100 + 32'(2*k+1));
      push(5'(2*k+2), 32'h100 + 32'(2*k+2));
      tick();
      if (k == 2) begin
        chk("t4_count6", {28'b0, count}, 32'd6);
        chk("t4_ready_at6", {31'b0, in_ready}, 32'd1);
      end
    end
    chk("t4_count_full", {28'b0, count}, 32'd8);
    chk("t4_full", {31'b0, full}, 32'd1);
    chk("t4_ready_full", {31'b0, in_ready}, 32'd0);
    chk("t4_hold_we1", {31'b0, we1}, 32'd0);
    lanes(1'b1, 5'd20, 32'hDEAD, 1'b1, 5'd21, 32'hBEEF);
    tick();
    chk("t4_ignored_count", {28'b0, count}, 32'd8);
    lanes(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    hold = 1'b0;
    tick();
    chk("t4_release_count", {28'b0, count}, 32'd6);
    chk("t4_release_ready", {31'b0, in_ready}, 32'd1);
    chk("t4_release_wa1", {27'b0, wa1}, 32'd1);
    chk("t4_release_wa2", {27'b0, wa2}, 32'd2);
    repeat (4) tick();
    chk("t4_drained", {31'b0, empty}, 32'd1);

    // Wrap-around stream with hold toggling every 3 cycles
    idx = 0;
    cyc = 0;
    while (idx < 40 && cyc < 400) begin
      hold = ((cyc / 3) % 2) == 1;
      if (cyc % 5 == 4)
        lanes(1'b0, 5'd0, 32'h0, 1'b1, 5'((idx % 31) + 1), 32'(idx));
      else
        lanes(1'b1, 5'((idx % 31) + 1), 32'(idx),
              (idx + 1) < 40, 5'(((idx + 1) % 31) + 1), 32'(idx + 1));
      if (in_ready === 1'b1) begin
        if (in0_valid) begin
          push(in0_addr, in0_data);
          idx++;
        end
        if (in1_valid) begin
          push(in1_addr, in1_data);
          idx++;
        end
      end
      tick();
      cyc++;
    end
    chk("t5_all_issued", 32'(idx), 32'd40);
    lanes(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    hold = 1'b0;
    repeat (12) tick();
    chk("t5_sb_drained", 32'(sb.size()), 32'd0);
    chk("t5_empty", {31'b0, empty}, 32'd1);

    // Reset mid-operation with five entries held
    hold = 1'b1;
    lanes(1'b1, 5'd11, 32'h511, 1'b1, 5'd12, 32'h512);
    tick();
    lanes(1'b1, 5'd13, 32'h513, 1'b1, 5'd14, 32'h514);
    tick();
    lanes(1'b1, 5'd15, 32'h515, 1'b0, 5'd0, 32'h0);
    tick();
    lanes(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("t6_count5", {28'b0, count}, 32'd5);
    rst = 1'b1;
    sb.delete();
    tick();
    chk("t6_we1", {31'b0, we1}, 32'd0);
    chk("t6_we2", {31'b0, we2}, 32'd0);
    chk("t6_count", {28'b0, count}, 32'd0);
    chk("t6_empty", {31'b0, empty}, 32'd1);
    rst = 1'b0;
    hold = 1'b0;
    repeat (6) tick();
    chk("t6_no_writes", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
